life_sequencer: RTL and testbench

- Controller for a ROWS x COLS grid of life cells.
- Sequences pattern loading (per-cell write/val), grid clearing, and generation stepping via the global cell enable.
- Sits between the host/user-interface logic and the cell array; it is the only driver of the array's write, val and enb nets.

---
 rtl/life_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_life_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/life_sequencer.sv
// life_sequencer: controller for a ROWS x COLS grid of life cells.
// Sequences per-cell pattern loads, whole-grid clears and generation stepping
// (single step or free-running at a programmable period). It is the only
// driver of the array's write strobes, val and enb nets.
//
// Optional feature macro: GEN_LIMIT_EN (adds gen_limit input and done output;
// RUN stops by itself after gen_limit generations).
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   start/stop/step/clear control requests (level sampled)
//   period                clocks per generation in RUN (0 behaves as 1)
//   load_valid/ready      load handshake; load_ready is combinational
//   load_row/col/val      load target and value
//   cell_write_row/col    row/column write strobes to the array
//   cell_val              value driven to the cells
//   cell_enb              one-cycle generation-advance pulse
//   generation            generations completed (wraps)
//   running               high while free-running
//   gen_limit, done       (GEN_LIMIT_EN only) run length limit and finish pulse
module life_sequencer #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    parameter int unsigned RW   = 3,
    parameter int unsigned CW   = 3,
    parameter int unsigned PW   = 16,
    parameter int unsigned GW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            step,
    input  logic            clear,
    input  logic [PW-1:0]   period,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [RW-1:0]   load_row,
    input  logic [CW-1:0]   load_col,
    input  logic            load_val,
    output logic [ROWS-1:0] cell_write_row,
    output logic [COLS-1:0] cell_write_col,
    output logic            cell_val,
    output logic            cell_enb,
    output logic [GW-1:0]   generation,
    output logic            running
`ifdef GEN_LIMIT_EN
    ,
    input  logic [GW-1:0]   gen_limit,
    output logic            done
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_STEP
    } state_e;

    state_e          state_q, state_d;
    logic [ROWS-1:0] wr_row_q, wr_row_d;
    logic [COLS-1:0] wr_col_q, wr_col_d;
    logic            val_q, val_d;
    logic            enb_q, enb_d;
    logic [GW-1:0]   gen_q, gen_d;
    logic            running_q, running_d;
    logic [RW-1:0]   clr_row_q, clr_row_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   period_m1;
    logic            period_hit;
    logic            go_clear;
    logic            limit_reached;
`ifdef GEN_LIMIT_EN
    logic [GW-1:0]   run_gen_q, run_gen_d;
    logic            done_q, done_d;
`endif

    // Period 0 behaves as 1; >= keeps a live period decrease from overshooting.
    assign period_m1  = (period == '0) ? '0 : period - PW'(1);
    assign period_hit = (cnt_q >= period_m1);

    // Limit is reached the cycle after the enb pulse that completed it.
`ifdef GEN_LIMIT_EN
    assign limit_reached = enb_q && (gen_limit != '0) && (run_gen_q == gen_limit);
`else
    assign limit_reached = 1'b0;
`endif

    assign load_ready = (state_q == S_IDLE) && !clear;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        wr_row_d  = '0;
        wr_col_d  = '0;
        val_d     = 1'b0;
        enb_d     = 1'b0;
        gen_d     = gen_q;
        running_d = 1'b0;
        clr_row_d = clr_row_q;
        cnt_d     = cnt_q;
        go_clear  = 1'b0;
`ifdef GEN_LIMIT_EN
        run_gen_d = run_gen_q;
        done_d    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    go_clear = 1'b1;
                end else if (load_valid) begin
                    state_d = S_LOAD;
                    val_d   = load_val;
                    // Out-of-range targets are accepted but produce no strobes.
                    if ((32'(load_row) < ROWS) && (32'(load_col) < COLS)) begin
                        wr_row_d = ROWS'(1) << load_row;
                        wr_col_d = COLS'(1) << load_col;
                    end
                end else if (step) begin
                    state_d = S_STEP;
                    enb_d   = 1'b1;
                    gen_d   = gen_q + GW'(1);
                end else if (start) begin
                    state_d   = S_RUN;
                    running_d = 1'b1;
                    cnt_d     = '0;
`ifdef GEN_LIMIT_EN
                    run_gen_d = '0;
`endif
                end
            end
            S_LOAD, S_STEP: begin
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (clear) begin
                    go_clear = 1'b1;
                end else if (32'(clr_row_q) == ROWS - 1) begin
                    state_d = S_IDLE;
                end else begin
                    clr_row_d = clr_row_q + RW'(1);
                end
            end
            S_RUN: begin
                if (clear) begin
                    go_clear = 1'b1;
                end else if (limit_reached) begin
                    state_d = S_IDLE;
`ifdef GEN_LIMIT_EN
                    done_d  = 1'b1;
`endif
                end else if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    running_d = 1'b1;
                    if (period_hit) begin
                        enb_d = 1'b1;
                        gen_d = gen_q + GW'(1);
                        cnt_d = '0;
`ifdef GEN_LIMIT_EN
                        run_gen_d = run_gen_q + GW'(1);
`endif
                    end else begin
                        cnt_d = cnt_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering (or restarting) CLEAR zeroes the generation count.
        if (go_clear) begin
            state_d   = S_CLEAR;
            clr_row_d = '0;
            gen_d     = '0;
        end

        // One row per cycle, all columns, value 0.
        if (state_d == S_CLEAR) begin
            wr_row_d = ROWS'(1) << clr_row_d;
            wr_col_d = '1;
            val_d    = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            val_q     <= 1'b0;
            enb_q     <= 1'b0;
            gen_q     <= '0;
            running_q <= 1'b0;
            clr_row_q <= '0;
            cnt_q     <= '0;
`ifdef GEN_LIMIT_EN
            run_gen_q <= '0;
            done_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            val_q     <= val_d;
            enb_q     <= enb_d;
            gen_q     <= gen_d;
            running_q <= running_d;
            clr_row_q <= clr_row_d;
            cnt_q     <= cnt_d;
`ifdef GEN_LIMIT_EN
            run_gen_q <= run_gen_d;
            done_q    <= done_d;
`endif
        end
    end

    assign cell_write_row = wr_row_q;
    assign cell_write_col = wr_col_q;
    assign cell_val       = val_q;
    assign cell_enb       = enb_q;
    assign generation     = gen_q;
    assign running        = running_q;
`ifdef GEN_LIMIT_EN
    assign done           = done_q;
`endif

endmodule

// File: tb/tb_life_sequencer.sv
// Directed testbench for life_sequencer: an 8x8 instance for the main checks
// and a 6x6 instance sharing the same stimulus for the out-of-range load case.
module tb_life_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, step, clear;
    logic [15:0] period;
    logic        load_valid;
    logic [2:0]  load_row, load_col;
    logic        load_val;

    logic        load_ready, cell_val, cell_enb, running;
    logic [7:0]  cell_write_row, cell_write_col;
    logic [15:0] generation;

    logic        load_ready6, cell_val6, cell_enb6, running6;
    logic [5:0]  cell_write_row6, cell_write_col6;
    logic [15:0] generation6;

`ifdef GEN_LIMIT_EN
    logic [15:0] gen_limit;
    logic        done, done6;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    life_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .clear(clear), .period(period), .load_valid(load_valid),
        .load_ready(load_ready), .load_row(load_row), .load_col(load_col),
        .load_val(load_val), .cell_write_row(cell_write_row),
        .cell_write_col(cell_write_col), .cell_val(cell_val),
        .cell_enb(cell_enb), .generation(generation), .running(running)
`ifdef GEN_LIMIT_EN
        , .gen_limit(gen_limit), .done(done)
`endif
    );

    life_sequencer #(.ROWS(6), .COLS(6)) dut6 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .clear(clear), .period(period), .load_valid(load_valid),
        .load_ready(load_ready6), .load_row(load_row), .load_col(load_col),
        .load_val(load_val), .cell_write_row(cell_write_row6),
        .cell_write_col(cell_write_col6), .cell_val(cell_val6),
        .cell_enb(cell_enb6), .generation(generation6), .running(running6)
`ifdef GEN_LIMIT_EN
        , .gen_limit(gen_limit), .done(done6)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0;
        period = 16'd4; load_valid = 1'b0; load_row = '0; load_col = '0; load_val = 1'b0;
`ifdef GEN_LIMIT_EN
        gen_limit = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row", 32'(cell_write_row), 32'h0);
        chk("rst_col", 32'(cell_write_col), 32'h0);
        chk("rst_val", 32'(cell_val), 32'h0);
        chk("rst_enb", 32'(cell_enb), 32'h0);
        chk("rst_gen", 32'(generation), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        reset = 1'b0;
        tick();

        // 1: single load
        load_valid = 1'b1; load_row = 3'd2; load_col = 3'd3; load_val = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("load_row", 32'(cell_write_row), 32'h04);
        chk("load_col", 32'(cell_write_col), 32'h08);
        chk("load_val", 32'(cell_val), 32'h1);
        chk("load_ready_busy", 32'(load_ready), 32'h0);
        tick();
        chk("load_done_row", 32'(cell_write_row), 32'h0);
        chk("load_done_ready", 32'(load_ready), 32'h1);

        // Five single steps bring generation to 5
        for (int i = 0; i < 5; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            chk("step_enb", 32'(cell_enb), 32'h1);
            chk("step_gen", 32'(generation), 32'(i + 1));
            chk("step_no_strobe", 32'(cell_write_row), 32'h0);
            tick();
            chk("step_enb_off", 32'(cell_enb), 32'h0);
        end
        chk("gen_before_clear", 32'(generation), 32'd5);

        // 2: clear sweeps every row with all columns and value 0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("clr_row", 32'(cell_write_row), 32'h1 << k);
            chk("clr_col", 32'(cell_write_col), 32'hFF);
            chk("clr_val", 32'(cell_val), 32'h0);
            chk("clr_gen", 32'(generation), 32'h0);
            chk("clr_ready", 32'(load_ready), 32'h0);
            tick();
        end
        chk("clr_end_row", 32'(cell_write_row), 32'h0);
        chk("clr_end_ready", 32'(load_ready), 32'h1);

        // 3: free run at period 4, stop suppresses the 16th-cycle pulse
        period = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_entry_running", 32'(running), 32'h1);
        chk("run_entry_enb", 32'(cell_enb), 32'h0);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("run4_enb", 32'(cell_enb), (k % 4 == 0) ? 32'h1 : 32'h0);
            chk("run4_gen", 32'(generation), 32'(k / 4));
            chk("run4_running", 32'(running), 32'h1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_enb", 32'(cell_enb), 32'h0);
        chk("stop_running", 32'(running), 32'h0);
        chk("stop_gen", 32'(generation), 32'd3);

        // 4: period 0 runs every cycle; step and load ignored in RUN
        period = 16'd0; start = 1'b1;
        tick();
        start = 1'b0; step = 1'b1; load_valid = 1'b1; load_row = 3'd1; load_col = 3'd1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("run0_enb", 32'(cell_enb), 32'h1);
            chk("run0_gen", 32'(generation), 32'(3 + k));
            chk("run0_ready", 32'(load_ready), 32'h0);
            chk("run0_row", 32'(cell_write_row), 32'h0);
        end
        stop = 1'b1; step = 1'b0; load_valid = 1'b0;
        tick();
        stop = 1'b0;
        chk("run0_stop_enb", 32'(cell_enb), 32'h0);
        chk("run0_stop_running", 32'(running), 32'h0);
        chk("run0_stop_gen", 32'(generation), 32'd9);

        // 5: one step, then an out-of-range load on the 6x6 instance
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step5_enb", 32'(cell_enb), 32'h1);
        chk("step5_gen", 32'(generation), 32'd10);
        tick();
        chk("step5_enb_off", 32'(cell_enb), 32'h0);
        chk("step5_gen_hold", 32'(generation), 32'd10);
        load_valid = 1'b1; load_row = 3'd7; load_col = 3'd2; load_val = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("oor_big_row", 32'(cell_write_row), 32'h80);
        chk("oor_big_col", 32'(cell_write_col), 32'h04);
        chk("oor_row", 32'(cell_write_row6), 32'h0);
        chk("oor_col", 32'(cell_write_col6), 32'h0);
        chk("oor_accepted", 32'(load_ready6), 32'h0);
        tick();
        chk("oor_ready_back", 32'(load_ready6), 32'h1);

`ifdef GEN_LIMIT_EN
        // 6a: generation limit of 5 at period 2
        gen_limit = 16'd5; period = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("lim_enb", 32'(cell_enb), ((k % 2 == 0) && (k <= 10)) ? 32'h1 : 32'h0);
            chk("lim_done", 32'(done), (k == 11) ? 32'h1 : 32'h0);
            chk("lim_running", 32'(running), (k <= 10) ? 32'h1 : 32'h0);
        end
        chk("lim_gen", 32'(generation), 32'd15);
        gen_limit = '0;
`endif

        // 6b: asynchronous reset in the middle of RUN
        period = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_rst_enb", 32'(cell_enb), 32'h1);
        chk("pre_rst_running", 32'(running), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_enb", 32'(cell_enb), 32'h0);
        chk("arst_running", 32'(running), 32'h0);
        chk("arst_gen", 32'(generation), 32'h0);
        chk("arst_row", 32'(cell_write_row), 32'h0);
        chk("arst_col", 32'(cell_write_col), 32'h0);
        chk("arst_val", 32'(cell_val), 32'h0);
`ifdef GEN_LIMIT_EN
        chk("arst_done", 32'(done), 32'h0);
`endif
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(load_ready), 32'h1);
        chk("post_rst_enb", 32'(cell_enb), 32'h0);
        chk("post_rst_gen", 32'(generation), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
